// File: rtl/pd_loop_sequencer.sv
// Initiator side of the PD filter stp/eop handshake: sample tick, saturated error,
// start pulse, eop capture and scaled/saturated actuator update. The setpoint port is ref_k because "ref" is a reserved word.
module pd_loop_sequencer #(
    parameter int n1  = 16,
    parameter int nU  = 32,
    parameter int nA  = 12,
    parameter int SH  = 8,
    parameter int DIV = 5000,
    parameter int TMO = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic signed [n1-1:0] ref_k,
    input  logic signed [n1-1:0] y_k,
    output logic signed [n1-1:0] e_k,
    output logic                 stp,
    input  logic                 eop,
    input  logic signed [nU-1:0] u_k,
    output logic signed [nA-1:0] act,
    output logic                 act_vld,
    output logic                 busy,
    output logic                 tmo_err,
    output logic                 ovr,
    output logic [1:0]           state_dbg
);
    // Handshake: stp is a single-cycle request; the filter answers with eop, and
    // u_k is only trusted in a cycle where eop=1 while we are in WAIT.
    typedef enum logic [1:0] {IDLE = 2'd0, SAMPLE = 2'd1, START = 2'd2, WAIT = 2'd3} state_t;

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int WW = $clog2(TMO + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TMO - 1);

    state_t               state, state_d;
    logic [CW-1:0]        cnt;
    logic [WW-1:0]        wcnt;
    logic                 tick, eop_hit, tmo_hit;
    logic signed [n1:0]   diff;
    logic signed [n1-1:0] e_sat;
    logic signed [nU-1:0] u_sh;
    logic signed [nA-1:0] a_sat;

    assign tick      = en && (cnt == CNT_LAST);
    assign eop_hit   = (state == WAIT) && eop;
    assign tmo_hit   = (state == WAIT) && !eop && (wcnt == WAIT_LAST);
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    // Error is formed one bit wider so the clamp sees the true sign.
    always_comb begin
        diff  = {ref_k[n1-1], ref_k} - {y_k[n1-1], y_k};
        e_sat = diff[n1-1:0];
        if (diff[n1] != diff[n1-1])
            e_sat = diff[n1] ? {1'b1, {(n1-1){1'b0}}} : {1'b0, {(n1-1){1'b1}}};
        u_sh  = u_k >>> SH;
        a_sat = u_sh[nA-1:0];
        if (!u_sh[nU-1] && (|u_sh[nU-2:nA-1]))
            a_sat = {1'b0, {(nA-1){1'b1}}};
        else if (u_sh[nU-1] && !(&u_sh[nU-2:nA-1]))
            a_sat = {1'b1, {(nA-1){1'b0}}};
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (tick) state_d = SAMPLE;
            SAMPLE:  state_d = START;
            START:   state_d = WAIT;
            WAIT:    if (eop_hit || tmo_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            wcnt    <= '0;
            e_k     <= '0;
            stp     <= 1'b0;
            act     <= '0;
            act_vld <= 1'b0;
            tmo_err <= 1'b0;
            ovr     <= 1'b0;
        end else begin
            state   <= state_d;
            stp     <= (state == SAMPLE);
            act_vld <= eop_hit;
            if (!en || cnt == CNT_LAST) cnt <= '0;
            else                        cnt <= cnt + 1'b1;
            if (state == SAMPLE) e_k <= e_sat;
            if (state == START)     wcnt <= '0;
            else if (state == WAIT) wcnt <= wcnt + 1'b1;
            if (eop_hit) act <= a_sat;
            if (tmo_hit) tmo_err <= 1'b1;
            // A tick that finds us busy is dropped, never queued.
            if (tick && state != IDLE) ovr <= 1'b1;
        end
    end

endmodule
